// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MEM-stage FSM state encoding and WB control bit positions.
// Ports: none (package only).
// Imported by the pipeline stages that need the state type or WB bit indices.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Bit positions inside the 2-bit WB control field
   localparam int WB_REGWRITE = 0;
   localparam int WB_MEMTOREG = 1;

endpackage

// File: rtl/mem_stage.sv
// MEM stage: runs loads/stores against data memory over a req/ack handshake,
// stalls the pipeline while an access is outstanding, traps misaligned and
// timed-out accesses, and passes WB control / address / dest reg to memwb.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mem_read_in, mem_write_in, wb_in, wn_in, addr_in, wdata_in   from EX/MEM
//   dm_req, dm_we, dm_addr, dm_wdata, dm_ack, dm_rdata           data memory bus
//   rd_out, addr_out, wb_out, wn_out                             to memwb
//   stall, misalign, bus_err                                     hazard / trap outputs
module mem_stage
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [1:0]  wb_in,
   input  logic [4:0]  wn_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic [31:0] rd_out,
   output logic [31:0] addr_out,
   output logic [1:0]  wb_out,
   output logic [4:0]  wn_out,
   output logic        stall,
   output logic        misalign,
   output logic        bus_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_q,    state_d;
   logic              dm_req_q,   dm_req_d;
   logic              dm_we_q,    dm_we_d;
   logic [31:0]       dm_addr_q,  dm_addr_d;
   logic [31:0]       dm_wdata_q, dm_wdata_d;
   logic [31:0]       rd_q,       rd_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   // Set when the access that just ended was a load that timed out; used to
   // squash the register write while that instruction sits in RESP.
   logic              tmo_ld_q,   tmo_ld_d;

   logic mem_op;
   logic acc;

   assign mem_op   = mem_read_in | mem_write_in;
   assign acc      = mem_op & (addr_in[1:0] == 2'b00);
   assign misalign = mem_op & (addr_in[1:0] != 2'b00);

   always_comb begin
      state_d    = state_q;
      dm_req_d   = dm_req_q;
      dm_we_d    = dm_we_q;
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      tmo_ld_d   = tmo_ld_q;
      bus_err    = 1'b0;
      stall      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tmo_ld_d = 1'b0;
            // Stall the issuing cycle itself so EX/MEM holds the instruction.
            stall    = acc;
            if (acc) begin
               dm_addr_d  = addr_in;
               dm_wdata_d = wdata_in;
               dm_we_d    = mem_write_in;
               dm_req_d   = 1'b1;
               cnt_d      = '0;
               state_d    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            stall = 1'b1;
            // An ack in the final wait cycle beats the timeout.
            if (dm_ack) begin
               dm_req_d = 1'b0;
               if (!dm_we_q) begin
                  rd_d = dm_rdata;
               end
               state_d = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               dm_req_d = 1'b0;
               rd_d     = '0;
               bus_err  = 1'b1;
               tmo_ld_d = ~dm_we_q;
               state_d  = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            // One unstalled cycle: memwb captures, EX/MEM advances.
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            dm_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         dm_req_q   <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         tmo_ld_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         dm_req_q   <= dm_req_d;
         dm_we_q    <= dm_we_d;
         dm_addr_q  <= dm_addr_d;
         dm_wdata_q <= dm_wdata_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         tmo_ld_q   <= tmo_ld_d;
      end
   end

   // WB control passes through unless the write must be suppressed.
   always_comb begin
      wb_out = wb_in;
      if (misalign || (state_q == ST_RESP && tmo_ld_q)) begin
         wb_out = 2'b00;
      end
   end

   assign dm_req   = dm_req_q;
   assign dm_we    = dm_we_q;
   assign dm_addr  = dm_addr_q;
   assign dm_wdata = dm_wdata_q;
   assign rd_out   = rd_q;
   assign addr_out = addr_in;
   assign wn_out   = wn_in;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table-driven combinational checks,
// directed load/store/timeout/reset sequences and randomized transactions
// scored against a transaction-level memory model.
module tb_mem_stage;

   localparam int TIMEOUT = 15;
   localparam int CNT_W   = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read_in, mem_write_in;
   logic [1:0]  wb_in;
   logic [4:0]  wn_in;
   logic [31:0] addr_in, wdata_in;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic [31:0] rd_out, addr_out;
   logic [1:0]  wb_out;
   logic [4:0]  wn_out;
   logic        stall, misalign, bus_err;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .wb_in(wb_in), .wn_in(wn_in), .addr_in(addr_in), .wdata_in(wdata_in),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .rd_out(rd_out), .addr_out(addr_out), .wb_out(wb_out), .wn_out(wn_out),
      .stall(stall), .misalign(misalign), .bus_err(bus_err)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state: word memory and last value presented on rd_out.
   logic [31:0] mem_m [logic [31:0]];
   logic [31:0] model_rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  wb;
      logic [4:0]  wn;
      logic [31:0] addr;
      logic        exp_stall;
      logic        exp_mis;
      logic [1:0]  exp_wb;
   } vec_t;

   // One instruction through the stage. ack_k = ACCESS cycle of the ack,
   // negative or >= TIMEOUT means memory never answers.
   task automatic run_txn(input logic rd, input logic wr, input logic [1:0] wb,
                          input logic [4:0] wn, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_k);
      logic        acc, mis, tmo;
      int          n_acc, stalls, exp_stalls;
      logic [31:0] rdata;
      acc   = (rd | wr) && (addr[1:0] == 2'b00);
      mis   = (rd | wr) && (addr[1:0] != 2'b00);
      tmo   = acc && (ack_k < 0 || ack_k >= TIMEOUT);
      n_acc = tmo ? TIMEOUT : ack_k + 1;
      exp_stalls = !acc ? 0 : (tmo ? TIMEOUT + 1 : ack_k + 2);
      rdata = mem_m.exists(addr) ? mem_m[addr] : (addr ^ 32'h5A5A_0F0F);

      @(negedge clk);
      mem_read_in = rd; mem_write_in = wr; wb_in = wb; wn_in = wn;
      addr_in = addr; wdata_in = wdata; dm_ack = 1'b0;
      #1;
      stalls = int'(stall);
      chk("issue_stall", 32'(stall), 32'(acc));
      chk("issue_misalign", 32'(misalign), 32'(mis));
      chk("addr_out", addr_out, addr);
      chk("wn_out", 32'(wn_out), 32'(wn));
      if (!acc) begin
         chk("idle_wb_out", 32'(wb_out), mis ? 32'd0 : 32'(wb));
         dm_ack = 1'b1; dm_rdata = $urandom;   // stray ack must be ignored
         @(posedge clk); #1;
         dm_ack = 1'b0;
         chk("idle_dm_req", 32'(dm_req), 32'd0);
         chk("idle_rd_out", rd_out, model_rd);
         chk("idle_bus_err", 32'(bus_err), 32'd0);
         return;
      end
      for (int a = 0; a < n_acc; a++) begin
         @(negedge clk);
         dm_ack   = !tmo && (a == ack_k);
         dm_rdata = dm_ack ? rdata : $urandom;
         #1;
         stalls += int'(stall);
         chk("acc_stall", 32'(stall), 32'd1);
         chk("acc_dm_req", 32'(dm_req), 32'd1);
         chk("acc_dm_we", 32'(dm_we), 32'(wr));
         chk("acc_dm_addr", dm_addr, addr);
         chk("acc_dm_wdata", dm_wdata, wdata);
         chk("acc_bus_err", 32'(bus_err), 32'(tmo && a == TIMEOUT - 1));
      end
      @(negedge clk);
      dm_ack = 1'b0;
      #1;
      if (tmo)     model_rd = 32'd0;
      else if (rd) model_rd = rdata;
      else         mem_m[addr] = wdata;
      chk("resp_stall", 32'(stall), 32'd0);
      chk("resp_dm_req", 32'(dm_req), 32'd0);
      chk("resp_rd_out", rd_out, model_rd);
      chk("resp_wb_out", 32'(wb_out), (tmo && rd) ? 32'd0 : 32'(wb));
      chk("resp_bus_err", 32'(bus_err), 32'd0);
      chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
   endtask

   initial begin
      vec_t vecs [6];
      vecs[0] = '{rd:0, wr:0, wb:2'b01, wn:5'd7,  addr:32'h55, exp_stall:0, exp_mis:0, exp_wb:2'b01};
      vecs[1] = '{rd:1, wr:0, wb:2'b11, wn:5'd3,  addr:32'h13, exp_stall:0, exp_mis:1, exp_wb:2'b00};
      vecs[2] = '{rd:0, wr:1, wb:2'b10, wn:5'd4,  addr:32'h22, exp_stall:0, exp_mis:1, exp_wb:2'b00};
      vecs[3] = '{rd:1, wr:0, wb:2'b01, wn:5'd8,  addr:32'h01, exp_stall:0, exp_mis:1, exp_wb:2'b00};
      vecs[4] = '{rd:1, wr:0, wb:2'b11, wn:5'd5,  addr:32'h40, exp_stall:1, exp_mis:0, exp_wb:2'b11};
      vecs[5] = '{rd:0, wr:0, wb:2'b11, wn:5'd9,  addr:32'h07, exp_stall:0, exp_mis:0, exp_wb:2'b11};

      rst = 1'b1; mem_read_in = 0; mem_write_in = 0; wb_in = 0; wn_in = 0;
      addr_in = 0; wdata_in = 0; dm_ack = 0; dm_rdata = 0;
      model_rd = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_dm_req", 32'(dm_req), 32'd0);
      chk("rst_dm_we", 32'(dm_we), 32'd0);
      chk("rst_dm_addr", dm_addr, 32'd0);
      chk("rst_dm_wdata", dm_wdata, 32'd0);
      chk("rst_rd_out", rd_out, 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      rst = 1'b0;

      // Combinational behaviour in IDLE
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         mem_read_in = vecs[i].rd; mem_write_in = vecs[i].wr; wb_in = vecs[i].wb;
         wn_in = vecs[i].wn; addr_in = vecs[i].addr;
         #1;
         chk("tbl_stall", 32'(stall), 32'(vecs[i].exp_stall));
         chk("tbl_misalign", 32'(misalign), 32'(vecs[i].exp_mis));
         chk("tbl_wb_out", 32'(wb_out), 32'(vecs[i].exp_wb));
         chk("tbl_addr_out", addr_out, vecs[i].addr);
         chk("tbl_wn_out", 32'(wn_out), 32'(vecs[i].wn));
         // Aligned accesses are withdrawn before the edge so they never issue.
         if (vecs[i].exp_stall) begin
            mem_read_in = 1'b0; mem_write_in = 1'b0;
         end
         @(posedge clk); #1;
         chk("tbl_dm_req", 32'(dm_req), 32'd0);
      end

      // Directed: load acked on 3rd ACCESS cycle, store acked immediately,
      // timeout, and ack coinciding with the timeout cycle.
      mem_m[32'h10] = 32'hDEAD_BEEF;
      run_txn(1, 0, 2'b11, 5'd2, 32'h10, 32'h0, 2);
      run_txn(0, 1, 2'b00, 5'd0, 32'h20, 32'h1234_5678, 0);
      run_txn(1, 0, 2'b11, 5'd6, 32'h24, 32'h0, -1);
      run_txn(1, 0, 2'b11, 5'd6, 32'h20, 32'h0, TIMEOUT - 1);
      run_txn(0, 0, 2'b01, 5'd7, 32'h55, 32'h0, 0);

      // Reset in the 2nd ACCESS cycle, then a late ack
      @(negedge clk);
      mem_read_in = 1'b1; mem_write_in = 1'b0; addr_in = 32'h30; wb_in = 2'b11;
      @(negedge clk);             // ACCESS cycle 0
      @(negedge clk);             // ACCESS cycle 1
      rst = 1'b1; mem_read_in = 1'b0;
      @(negedge clk);
      rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
      #1;
      chk("rstmid_dm_req", 32'(dm_req), 32'd0);
      chk("rstmid_stall", 32'(stall), 32'd0);
      chk("rstmid_rd_out", rd_out, 32'd0);
      @(negedge clk);
      dm_ack = 1'b0;
      #1;
      chk("late_ack_rd_out", rd_out, 32'd0);
      chk("late_ack_dm_req", 32'(dm_req), 32'd0);
      model_rd = 32'd0;

      // Randomized back-to-back traffic
      for (int t = 0; t < 60; t++) begin
         int          kind, ak;
         logic [31:0] a;
         kind = $urandom_range(0, 2);
         a    = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
         case ($urandom_range(0, 7))
            0:       ak = -1;
            1:       ak = TIMEOUT - 1;
            default: ak = $urandom_range(0, 5);
         endcase
         run_txn(kind == 1, kind == 2, 2'($urandom), 5'($urandom), a, $urandom, ak);
      end

      @(negedge clk);
      mem_read_in = 1'b0; mem_write_in = 1'b0;
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
